// File: rtl/adder64_rr_arbiter.sv
// Round-robin front end that shares one pipelined adder among NUM_REQ requesters; optional checker: ADDER64_ARB_CHECK_EN.
// Latency: accept at T -> add_en at T+1 -> rsp_valid at T+LATENCY+2.
// Backpressure: req_ready is a one-hot grant (one issue per cycle); responses cannot be stalled and must always be sunk.
module adder64_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH:0]           rsp_sum,
    output logic                          add_en,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic                          add_o_en,
    input  logic [DATA_WIDTH:0]           add_result,
    output logic                          busy,
    output logic                          err
);

    // Round-robin pointer: the last granted requester
    logic [ID_W-1:0] ptr;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_id;
    // ID of the operation currently on add_a/add_b
    logic [ID_W-1:0] iss_id;

    // Tag pipe that tracks which requester owns each adder stage
    logic [LATENCY-1:0] tag_vld;
    logic [ID_W-1:0]    tag_id [LATENCY];

    logic            tail_vld;
    logic [ID_W-1:0] tail_id;

    assign tail_vld = tag_vld[LATENCY-1];
    assign tail_id  = tag_id[LATENCY-1];

    function automatic logic [ID_W-1:0] wrap_id(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Grant: first valid requester searching upward from ptr+1, wrapping around
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_any && req_valid[wrap_id(int'(ptr) + k)]) begin
                gnt_any = 1'b1;
                gnt_id  = wrap_id(int'(ptr) + k);
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            req_ready = onehot(gnt_id);
        end
    end

    // Issue stage: register the granted operands toward the adder and advance the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            add_en <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
            iss_id <= '0;
            ptr    <= ID_W'(NUM_REQ - 1);
        end else begin
            add_en <= gnt_any;
            if (gnt_any) begin
                add_a  <= req_a[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                add_b  <= req_b[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                iss_id <= gnt_id;
                ptr    <= gnt_id;
            end
        end
    end

    // Tag pipe: stage 0 samples the issue stage as the adder samples i_en, so the tail lines up with o_en
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_vld <= {tag_vld[LATENCY-2:0], add_en};
            tag_id[0] <= iss_id;
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Return: route the adder result to the owner recorded at the tail of the tag pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_sum   <= '0;
        end else begin
            rsp_valid <= '0;
            if (add_o_en && tail_vld) begin
                rsp_valid <= onehot(tail_id);
                rsp_sum   <= add_result;
            end
        end
    end

    assign busy = add_en | (|tag_vld);

`ifdef ADDER64_ARB_CHECK_EN
    // Sticky flag for any disagreement between the tag pipe tail and the adder's o_en
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (add_o_en != tail_vld) begin
            err <= 1'b1;
        end
    end

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready))
        else $error("req_ready has more than one bit set: %b", req_ready);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder64_rr_arbiter.sv
// Bench for adder64_rr_arbiter: directed tests with a scoreboard model of grant/issue/return timing.
// Latency: the model expects add_en at accept+1 and rsp_valid at accept+6.
// Backpressure: none on responses; the bench adder is a fixed 4-stage pipe cleared by rst.
module tb_adder64_rr_arbiter;
    localparam int DW = 64;
    localparam int NR = 4;
    localparam int L  = 4;
`ifdef ADDER64_ARB_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '1;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic [NR-1:0]     rsp_valid;
    logic [DW:0]       rsp_sum;
    logic              add_en;
    logic [DW-1:0]     add_a, add_b;
    logic              add_o_en;
    logic [DW:0]       add_result;
    logic              busy, err;
    logic              force_oen = 1'b0;

    always #5 clk = ~clk;

    adder64_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(L), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
        .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_o_en(add_o_en), .add_result(add_result),
        .busy(busy), .err(err)
    );

    // Stand-in for the shared adder: L-cycle pipe, reset from the same rst
    logic        ae  [L];
    logic [DW:0] asum[L];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                ae[i]   <= 1'b0;
                asum[i] <= '0;
            end
        end else begin
            ae[0]   <= add_en;
            asum[0] <= {1'b0, add_a} + {1'b0, add_b};
            for (int i = 1; i < L; i++) begin
                ae[i]   <= ae[i-1];
                asum[i] <= asum[i-1];
            end
        end
    end
    assign add_o_en   = ae[L-1] | force_oen;
    assign add_result = asum[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: expected events indexed by the cycle they must appear in
    bit          iss_v[16];
    logic [63:0] iss_a[16];
    logic [63:0] iss_b[16];
    bit          rsp_v[16];
    int          rsp_id[16];
    logic [64:0] rsp_s[16];
    int          mptr = NR - 1;
    bit          exp_err = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            iss_v[i] = 1'b0;
            rsp_v[i] = 1'b0;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        int n;
        int g;
        int idx;
        bit busy_e;
        bit due_next;
        logic [63:0] a, b;
        n = cyc;
        g = -1;
        if (!rst) begin
            for (int k = 1; k <= NR; k++) begin
                idx = (mptr + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        check("req_ready", 65'(req_ready), (g < 0) ? 65'd0 : (65'd1 << g));
        check("add_en", 65'(add_en), 65'(iss_v[n%16]));
        if (iss_v[n%16]) begin
            check("add_a", 65'(add_a), 65'(iss_a[n%16]));
            check("add_b", 65'(add_b), 65'(iss_b[n%16]));
        end
        check("rsp_valid", 65'(rsp_valid), rsp_v[n%16] ? (65'd1 << rsp_id[n%16]) : 65'd0);
        if (rsp_v[n%16]) check("rsp_sum", rsp_sum, rsp_s[n%16]);
        busy_e = 1'b0;
        for (int k = 1; k <= 5; k++) if (rsp_v[(n+k)%16]) busy_e = 1'b1;
        check("busy", 65'(busy), 65'(busy_e));
        check("err", 65'(err), 65'(exp_err));

        iss_v[n%16] = 1'b0;
        rsp_v[n%16] = 1'b0;
        due_next = rsp_v[(n+1)%16];
        if (g >= 0) begin
            a = req_a[g*DW +: DW];
            b = req_b[g*DW +: DW];
            iss_v[(n+1)%16] = 1'b1;
            iss_a[(n+1)%16] = a;
            iss_b[(n+1)%16] = b;
            rsp_v[(n+6)%16]  = 1'b1;
            rsp_id[(n+6)%16] = g;
            rsp_s[(n+6)%16]  = {1'b0, a} + {1'b0, b};
            mptr = g;
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                iss_v[i] = 1'b0;
                rsp_v[i] = 1'b0;
            end
            mptr    = NR - 1;
            exp_err = 1'b0;
        end else if (CHK && (add_o_en !== due_next)) begin
            exp_err = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [63:0] a, input logic [63:0] b);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
    endtask

    initial begin
        int t;
        // 1. Reset with every requester asking
        for (int k = 0; k < 3; k++) begin
            #1;
            check("reset_ready", 65'(req_ready), 65'd0);
            step();
        end
        check("reset_add_en", 65'(add_en), 65'd0);
        check("reset_busy", 65'(busy), 65'd0);
        rst = 1'b0;
        req_valid = '0;
        step();

        // 2. Single op with full carry-out
        set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        req_valid = 4'b0010;
        t = cyc;
        #1;
        check("single_ready", 65'(req_ready), 65'h2);
        step();
        req_valid = '0;
        check("single_add_en", 65'(add_en), 65'd1);
        repeat (5) step();
        check("single_lat", 65'(cyc - t), 65'd6);
        check("single_rsp_valid", 65'(rsp_valid), 65'h2);
        check("single_rsp_sum", rsp_sum, 65'h1_0000_0000_0000_0000);
        repeat (2) step();

        // 3. Contention after a fresh reset: expect 0,1,2,3,0,1,2,3
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) begin
                set_op(i, 64'h1111_0000_0000_0000 * (i + 1) + 64'(k), 64'hF000_0000_0000_0000 + 64'(k * 3 + i));
            end
            #1;
            check("contend_grant", 65'(req_ready), 65'd1 << (k % 4));
            step();
        end
        req_valid = '0;
        repeat (8) step();

        // 4. Single requester streaming, accepted every cycle
        req_valid = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            set_op(2, {$urandom, $urandom}, {$urandom, $urandom});
            #1;
            check("stream_grant", 65'(req_ready), 65'h4);
            step();
        end
        req_valid = '0;
        repeat (8) step();

        // 5. Reset while three ops are in flight
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_op(0, 64'(100 + k), 64'(200 + k));
            step();
        end
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("flush_no_rsp", 65'(rsp_valid), 65'd0);
            step();
        end
        set_op(3, 64'd5, 64'd7);
        req_valid = 4'b1000;
        t = cyc;
        step();
        req_valid = '0;
        repeat (5) step();
        check("post_reset_lat", 65'(cyc - t), 65'd6);
        check("post_reset_rsp_valid", 65'(rsp_valid), 65'h8);
        check("post_reset_rsp_sum", rsp_sum, 65'd12);
        repeat (3) step();

        // 6. Spurious o_en with an empty tag pipe
        force_oen = 1'b1;
        step();
        force_oen = 1'b0;
        check("mismatch_err", 65'(err), 65'(CHK));
        check("mismatch_no_rsp", 65'(rsp_valid), 65'd0);
        repeat (3) step();
        check("mismatch_err_sticky", 65'(err), 65'(CHK));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
